// File: rtl/data_bus_if.sv
// SRAM-like data bus (req/addr_ok/data_ok) between the MEM-stage access controller
// and the data memory or its bridge.
interface data_bus_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  data_req;
    logic                  data_wr;
    logic [1:0]            data_size_o;
    logic [ADDR_WIDTH-1:0] data_addr;
    logic [31:0]           data_wdata;
    logic                  data_addr_ok;
    logic                  data_data_ok;
    logic [31:0]           data_rdata;

    modport master (
        output data_req, data_wr, data_size_o, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size_o, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_mem_access_ctrl.sv
// MEM-stage load/store sequencer for the SRAM-like data bus: one outstanding access,
// store lane replication, load extraction/extension, flush drain. Option: UNALIGNED_EXC_EN.
module data_mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter bit PADDR_MAP  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic                  flush,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            data_size,
    input  logic                  data_ext_type,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  mem_stall,
    output logic [31:0]           load_result,
    output logic                  load_done,
    output logic                  adel,
    output logic                  ades,
    output logic [ADDR_WIDTH-1:0] badvaddr,
    data_bus_if.master            bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, DRAIN} state_t;

    state_t                state_reg;
    logic                  req_reg;
    logic                  wr_reg;
    logic [1:0]            size_reg;
    logic                  ext_reg;
    logic [1:0]            off_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [31:0]           wdata_reg;
    logic [31:0]           load_result_reg;
    logic                  load_done_reg;

    logic                  is_half, is_word, mem_op, addr_err, access;
    logic [ADDR_WIDTH-1:0] eff_addr, phys_addr;
    logic [31:0]           lane_wdata;
    logic [15:0]           rd_shift;
    logic [31:0]           load_ext;

    assign is_half = (data_size == 2'd1);
    assign is_word = data_size[1];
    assign mem_op  = mem_valid & (memRead | memWrite);

`ifdef UNALIGNED_EXC_EN
    assign addr_err = mem_op & ((is_half & mem_addr[0]) | (is_word & (|mem_addr[1:0])));
    assign eff_addr = mem_addr;
    assign adel     = addr_err & memRead & ~reset;
    assign ades     = addr_err & ~memRead & ~reset;
    assign badvaddr = (addr_err & ~reset) ? mem_addr : '0;
`else
    // Misaligned accesses are silently rounded down to the natural boundary.
    assign addr_err = 1'b0;
    assign eff_addr = {mem_addr[ADDR_WIDTH-1:2], mem_addr[1] & ~is_word,
                       mem_addr[0] & ~is_half & ~is_word};
    assign adel     = 1'b0;
    assign ades     = 1'b0;
    assign badvaddr = '0;
`endif

    assign access = mem_op & ~flush & ~addr_err;

    generate
        if (PADDR_MAP) begin : g_map
            // kseg0/kseg1 fold onto the low 512 MB of physical space
            assign phys_addr = (eff_addr[ADDR_WIDTH-1 -: 2] == 2'b10)
                             ? {3'b000, eff_addr[ADDR_WIDTH-4:0]} : eff_addr;
        end else begin : g_pass
            assign phys_addr = eff_addr;
        end

        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wdata[8*gi +: 8] = (data_size == 2'd0) ? mem_wdata[7:0] :
                                           is_half ? mem_wdata[8*(gi%2) +: 8] :
                                                     mem_wdata[8*gi +: 8];
        end
    endgenerate

    assign rd_shift = 16'(bus.data_rdata >> {off_reg, 3'b000});

    always_comb begin
        load_ext = bus.data_rdata;
        case (size_reg)
            2'd0: load_ext = ext_reg ? {24'b0, rd_shift[7:0]}
                                     : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1: load_ext = ext_reg ? {16'b0, rd_shift}
                                     : {{16{rd_shift[15]}}, rd_shift};
            default: load_ext = bus.data_rdata;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        case (state_reg)
            IDLE, DRAIN: mem_stall = access;
            REQ, WAIT:   mem_stall = 1'b1;
            default:     mem_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            req_reg         <= 1'b0;
            wr_reg          <= 1'b0;
            size_reg        <= 2'd0;
            ext_reg         <= 1'b0;
            off_reg         <= 2'd0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            load_result_reg <= '0;
            load_done_reg   <= 1'b0;
        end else begin
            load_done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        wr_reg    <= memWrite;
                        size_reg  <= data_size;
                        ext_reg   <= data_ext_type;
                        off_reg   <= eff_addr[1:0];
                        addr_reg  <= phys_addr;
                        wdata_reg <= lane_wdata;
                        req_reg   <= 1'b1;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (bus.data_addr_ok) begin
                        req_reg   <= 1'b0;
                        state_reg <= flush ? DRAIN : WAIT;
                    end else if (flush) begin
                        req_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                WAIT: begin
                    if (bus.data_data_ok) begin
                        if (flush) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg       <= DONE;
                            load_result_reg <= load_ext;
                            load_done_reg   <= ~wr_reg;
                        end
                    end else if (flush) begin
                        state_reg <= DRAIN;
                    end
                end
                DONE:  state_reg <= IDLE;
                DRAIN: if (bus.data_data_ok) state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Request drops in the reset cycle itself, not one edge later.
    assign bus.data_req    = req_reg & ~reset;
    assign bus.data_wr     = wr_reg;
    assign bus.data_size_o = size_reg;
    assign bus.data_addr   = addr_reg;
    assign bus.data_wdata  = wdata_reg;
    assign load_result     = load_result_reg;
    assign load_done       = load_done_reg;
endmodule

// File: tb/tb_data_mem_access_ctrl.sv
// Bench for data_mem_access_ctrl: directed cases plus randomized loads/stores against a
// transaction-level model, with a bus slave applying configurable addr_ok/data_ok delays.
module tb_data_mem_access_ctrl;
`ifdef UNALIGNED_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, mem_valid, flush, memRead, memWrite, data_ext_type;
    logic [1:0]  data_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_stall, load_done, adel, ades;
    logic [31:0] load_result, badvaddr;

    data_bus_if #(.ADDR_WIDTH(32)) bus ();

    data_mem_access_ctrl #(.ADDR_WIDTH(32), .PADDR_MAP(1'b1)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .flush(flush),
        .memRead(memRead), .memWrite(memWrite), .data_size(data_size),
        .data_ext_type(data_ext_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_stall(mem_stall), .load_result(load_result), .load_done(load_done),
        .adel(adel), .ades(ades), .badvaddr(badvaddr), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int          d1_cfg = 0, d2_cfg = 0;
    logic [31:0] rd_cfg = 32'h0;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_misaligned(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] m_align(input logic [31:0] a, input logic [1:0] sz);
        if (EXC_EN) return a;
        if (sz == 2'd1) return a - a % 2;
        if (sz == 2'd2) return a - a % 4;
        return a;
    endfunction

    function automatic logic [31:0] m_phys(input logic [31:0] a);
        if (a >= 32'h8000_0000 && a < 32'hC000_0000) return a % 32'h2000_0000;
        return a;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return {24'b0, wd[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'b0, wd[15:0]} * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                          input logic [1:0] sz, input bit zx);
        logic [31:0]     v;
        longint unsigned x;
        if (sz == 2'd2) return rd;
        v = rd >> (8 * (a % 4));
        if (sz == 2'd0) begin
            x = v % 256;
            if (!zx && x >= 128) x = x + 64'hFFFF_FF00;
        end else begin
            x = v % 65536;
            if (!zx && x >= 32768) x = x + 64'hFFFF_0000;
        end
        return x[31:0];
    endfunction

    // ---------------- bus slave ----------------
    initial begin
        bit pending, acc_s, done_s;
        int acnt, dcnt;
        pending = 0; acnt = 0; dcnt = 0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            acc_s  = bus.data_req && bus.data_addr_ok;
            done_s = bus.data_data_ok;
            @(posedge clk);
            #2;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata   = $urandom;
            if (reset) begin
                pending = 0;
                acnt    = 0;
            end else begin
                if (done_s) pending = 0;
                if (acc_s) begin pending = 1; dcnt = 0; acnt = 0; end
                if (pending) begin
                    if (dcnt >= d2_cfg) begin
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata   = rd_cfg;
                    end
                    dcnt++;
                end else if (bus.data_req) begin
                    if (acnt == d1_cfg) bus.data_addr_ok = 1'b1;
                    acnt++;
                end else begin
                    acnt = 0;
                end
            end
        end
    end

    // ---------------- one complete MEM-stage access ----------------
    task automatic run_op(input string name, input bit is_st, input logic [1:0] sz, input bit zx,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int d1, input int d2, input logic [31:0] rd);
        bit          err, done;
        logic [31:0] ea, exp_ld;
        int          stall_c, req_c, ld_c;
        err    = EXC_EN && m_misaligned(addr, sz);
        ea     = m_align(addr, sz);
        exp_ld = m_load(rd, ea, sz, zx);
        d1_cfg = d1; d2_cfg = d2; rd_cfg = rd;
        mem_valid = 1'b1; memRead = !is_st; memWrite = is_st; data_size = sz;
        data_ext_type = zx; mem_addr = addr; mem_wdata = wd; flush = 1'b0;
        stall_c = 0; req_c = 0; ld_c = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus.data_req) begin
                req_c++;
                check({name, "/bus"}, {bus.data_wr, bus.data_size_o, bus.data_addr},
                      {is_st, sz, m_phys(ea)});
                if (is_st) check({name, "/wdata"}, bus.data_wdata, m_store(wd, sz));
            end
            if (load_done) begin
                ld_c++;
                check({name, "/load_result"}, load_result, exp_ld);
            end
            if (mem_stall) stall_c++;
            else begin
                done = 1;
                check({name, "/exc"}, {adel, ades, badvaddr},
                      {err && !is_st, err && is_st, err ? addr : 32'h0});
            end
            tick();
        end
        mem_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        check({name, "/completed"}, done, 1'b1);
        check({name, "/stall_cycles"}, stall_c, err ? 0 : d1 + d2 + 3);
        check({name, "/req_cycles"}, req_c, err ? 0 : d1 + 1);
        check({name, "/load_done_count"}, ld_c, (!is_st && !err) ? 1 : 0);
        $display("op %s %s size=%0d addr=%h wdata=%h d1=%0d d2=%0d stall=%0d req=%0d ld=%0d res=%h",
                 name, is_st ? "ST" : "LD", sz, addr, wd, d1, d2, stall_c, req_c, ld_c, load_result);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dok_c, req_c, ld_c;
        logic [31:0] res, a, wd;
        logic [1:0]  sz;
        bit          st;

        reset = 1'b1; mem_valid = 1'b0; flush = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        data_size = 2'd0; data_ext_type = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        tick(); tick();
        @(negedge clk);
        check("reset_state",
              {bus.data_req, bus.data_wr, load_done, adel, ades, mem_stall,
               bus.data_addr, bus.data_wdata, load_result},
              96'h0);
        tick();
        reset = 1'b0;

        // Directed accesses
        run_op("lw_basic", 0, 2'd2, 0, 32'h8000_0004, 32'h5555_AAAA, 0, 0, 32'hDEAD_BEEF);
        run_op("lb_sign",  0, 2'd0, 0, 32'h8000_0003, 32'h0,         0, 0, 32'h8000_0000);
        run_op("lbu_zero", 0, 2'd0, 1, 32'h8000_0003, 32'h0,         0, 0, 32'h8000_0000);
        run_op("sh_kseg1", 1, 2'd1, 0, 32'hA000_0002, 32'h0000_1234, 0, 0, 32'h0);
        run_op("sw_slow",  1, 2'd2, 0, 32'h8000_0040, 32'hCAFE_0001, 3, 1, 32'h0);
        run_op("lw_misal", 0, 2'd2, 0, 32'h8000_0002, 32'h0,         0, 0, 32'h1234_5678);
        run_op("lh_kuseg", 0, 2'd1, 0, 32'h0040_0006, 32'h0,         1, 2, 32'h8001_7FFE);

        // Flush in WAIT: drain the returning data, then the next load proceeds
        d1_cfg = 0; d2_cfg = 3; rd_cfg = 32'h1111_1111;
        mem_valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; data_size = 2'd2;
        data_ext_type = 1'b0; mem_addr = 32'h8000_0010;
        @(negedge clk); tick();
        @(negedge clk); check("drain/req_accepted", {bus.data_req, bus.data_addr_ok}, 2'b11);
        tick(); flush = 1'b1;
        @(negedge clk); tick();
        flush = 1'b0; mem_addr = 32'h8000_0020;
        dok_c = -1; req_c = -1; ld_c = 0; res = 32'h0;
        for (int c = 3; c < 25 && ld_c == 0; c++) begin
            @(negedge clk);
            if (c == 3) check("drain/stall_waiting", mem_stall, 1'b1);
            if (bus.data_data_ok && dok_c < 0) dok_c = c;
            if (bus.data_req && req_c < 0) req_c = c;
            if (load_done) begin ld_c++; res = load_result; end
            tick();
            if (dok_c >= 0) begin rd_cfg = 32'hC0DE_F00D; d2_cfg = 0; end
        end
        mem_valid = 1'b0; memRead = 1'b0;
        check("drain/req_after_data_ok", (dok_c >= 0) && (req_c > dok_c), 1'b1);
        check("drain/one_load_done", ld_c, 1);
        check("drain/next_result", res, 32'hC0DE_F00D);
        $display("op drain_flush data_ok@%0d next_req@%0d result=%h", dok_c, req_c, res);

        // Flush in REQ before acceptance drops the request
        d1_cfg = 20;
        mem_valid = 1'b1; memRead = 1'b1; data_size = 2'd2; mem_addr = 32'h8000_0100;
        @(negedge clk); tick();
        @(negedge clk); check("req_flush/req_up", bus.data_req, 1'b1);
        tick(); flush = 1'b1;
        @(negedge clk); tick();
        flush = 1'b0; mem_valid = 1'b0; memRead = 1'b0;
        @(negedge clk); check("req_flush/dropped", {bus.data_req, mem_stall}, 2'b00);
        tick();
        $display("op req_flush done");

        // Reset mid-transaction: request falls in the reset cycle
        mem_valid = 1'b1; memRead = 1'b1; data_size = 2'd2; mem_addr = 32'h8000_0200;
        @(negedge clk); tick();
        @(negedge clk); check("mid_reset/req_up", bus.data_req, 1'b1);
        tick(); reset = 1'b1;
        @(negedge clk); check("mid_reset/req_same_cycle", bus.data_req, 1'b0);
        tick(); reset = 1'b0; mem_valid = 1'b0; memRead = 1'b0;
        @(negedge clk); check("mid_reset/idle", {bus.data_req, mem_stall, load_done}, 3'b000);
        tick();
        $display("op mid_reset done");

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0:       a = 32'h8000_0000 + $urandom % 32'h2000_0000;
                1:       a = 32'hA000_0000 + $urandom % 32'h2000_0000;
                default: a = $urandom % 32'h8000_0000;
            endcase
            if ($urandom_range(0, 3) != 0) a = a - a % (32'd1 << sz);
            wd = $urandom;
            run_op($sformatf("rnd%0d", i), st, sz, 1'($urandom_range(0, 1)), a, wd,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("gap/idle", {bus.data_req, mem_stall}, 2'b00);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
